// File: rtl/ralu_sequencer_if.sv
// Command and RALU control bundle for ralu_sequencer.
//   slave  : sequencer side (takes commands and RALU results, drives control word and status)
//   master : decoder/RALU side
//   cmd_*      : command handshake and fields
//   ralu_*     : RALU result/carry feeding back to the sequencer
//   DataIn..v  : RALU control word
//   done/result/carry/err : command completion status
interface ralu_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_rd;
    logic [ADDR_WIDTH-1:0] cmd_ra;
    logic [ADDR_WIDTH-1:0] cmd_rb;
    logic [DATA_WIDTH-1:0] cmd_imm;
    logic [DATA_WIDTH-1:0] ralu_r;
    logic                  ralu_pout;
    logic [DATA_WIDTH-1:0] DataIn;
    logic [3:0]            S;
    logic                  M;
    logic                  Pin;
    logic                  ISR;
    logic                  ISL;
    logic                  A;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] adr;
    logic [3:0]            v;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;
    logic                  carry;
    logic                  err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm, ralu_r, ralu_pout,
        output cmd_ready, DataIn, S, M, Pin, ISR, ISL, A, wr, adr, v, done, result, carry, err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm, ralu_r, ralu_pout,
        input  cmd_ready, DataIn, S, M, Pin, ISR, ISL, A, wr, adr, v, done, result, carry, err
    );
endinterface

// File: rtl/ralu_sequencer.sv
// Macro-command sequencer for the RALU datapath.
// Accepts one LDI/ADD/SHL/MUL command per handshake and steps the RALU control
// word one clock per step, capturing R/Pout on the final step and pulsing done.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : ralu_sequencer_if slave (command, RALU feedback, control word, status)
module ralu_sequencer #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    ralu_sequencer_if.slave   bus
);
    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE, ST_L_IMM, ST_WR, ST_LD_A, ST_LD_B, ST_EXEC, ST_SHIFT, ST_DONE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [2:0]    r_op, w_op_nxt;
    logic [AW-1:0] r_rd, r_ra, r_rb, w_rd_nxt, w_ra_nxt, w_rb_nxt;
    logic [DW-1:0] r_imm, w_imm_nxt;
    logic [1:0]    r_cnt, w_cnt_nxt;
    logic          r_err, w_err_nxt;
    logic          w_capture;

    logic [DW-1:0] r_result, r_datain, w_datain;
    logic          r_carry;
    logic [3:0]    r_s, w_s, r_v, w_v;
    logic          r_m, w_m, r_a, w_a, r_wr, w_wr;
    logic [AW-1:0] r_adr, w_adr;
    logic          r_done, r_ready;

    // Next-state and field latching
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_rd_nxt    = r_rd;
        w_ra_nxt    = r_ra;
        w_rb_nxt    = r_rb;
        w_imm_nxt   = r_imm;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_op_nxt  = bus.cmd_op;
                    w_rd_nxt  = bus.cmd_rd;
                    w_ra_nxt  = bus.cmd_ra;
                    w_rb_nxt  = bus.cmd_rb;
                    w_imm_nxt = bus.cmd_imm;
                    w_err_nxt = 1'b0;
                    case (bus.cmd_op)
                        OP_NOP: w_state_nxt = ST_DONE;
                        OP_LDI: w_state_nxt = ST_L_IMM;
                        OP_ADD: w_state_nxt = ST_LD_A;
                        OP_MUL: w_state_nxt = ST_LD_A;
                        OP_SHL: begin
                            w_state_nxt = ST_LD_B;
                            w_cnt_nxt   = bus.cmd_imm[1:0];
                        end
                        default: begin
                            w_state_nxt = ST_DONE;
                            w_err_nxt   = 1'b1;
                        end
                    endcase
                end
            end
            ST_L_IMM: w_state_nxt = ST_WR;
            ST_WR: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_LD_A: w_state_nxt = ST_LD_B;
            ST_LD_B: w_state_nxt = (r_op == OP_SHL) ? ST_SHIFT : ST_EXEC;
            ST_EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_SHIFT: begin
                if (r_cnt == 2'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Control word for the upcoming state, so the word register lines up with the state register
    always_comb begin
        w_datain = '0;
        w_s      = 4'b0000;
        w_m      = 1'b0;
        w_a      = 1'b0;
        w_wr     = 1'b0;
        w_adr    = '0;
        w_v      = 4'b0000;
        case (w_state_nxt)
            ST_L_IMM: begin
                w_datain = w_imm_nxt;
                w_a      = 1'b1;
                w_v      = 4'b0001;
            end
            ST_WR: begin
                w_wr  = 1'b1;
                w_adr = w_rd_nxt;
            end
            ST_LD_A: begin
                w_adr = w_ra_nxt;
                w_v   = 4'b0001;
            end
            ST_LD_B: begin
                w_adr = (w_op_nxt == OP_SHL) ? w_ra_nxt : w_rb_nxt;
                w_v   = 4'b0110;
            end
            ST_EXEC: begin
                if (w_op_nxt == OP_ADD) begin
                    w_s   = 4'b1001;
                    w_m   = 1'b1;
                    w_wr  = 1'b1;
                    w_adr = w_rd_nxt;
                end else begin
                    w_s = 4'b0100;
                end
            end
            ST_SHIFT: begin
                w_s = 4'b0101;
                w_v = 4'b0010;
                // last shift also writes the destination
                if (w_cnt_nxt == 2'd0) begin
                    w_wr  = 1'b1;
                    w_adr = w_rd_nxt;
                end
            end
            default: ;
        endcase
    end

    // State, fields, registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_op     <= 3'b000;
            r_rd     <= '0;
            r_ra     <= '0;
            r_rb     <= '0;
            r_imm    <= '0;
            r_cnt    <= 2'd0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_datain <= '0;
            r_s      <= 4'b0000;
            r_m      <= 1'b0;
            r_a      <= 1'b0;
            r_wr     <= 1'b0;
            r_adr    <= '0;
            r_v      <= 4'b0000;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_rd     <= w_rd_nxt;
            r_ra     <= w_ra_nxt;
            r_rb     <= w_rb_nxt;
            r_imm    <= w_imm_nxt;
            r_cnt    <= w_cnt_nxt;
            r_err    <= w_err_nxt;
            r_datain <= w_datain;
            r_s      <= w_s;
            r_m      <= w_m;
            r_a      <= w_a;
            r_wr     <= w_wr;
            r_adr    <= w_adr;
            r_v      <= w_v;
            r_done   <= (w_state_nxt == ST_DONE);
            r_ready  <= (w_state_nxt == ST_IDLE);
            if (w_capture) begin
                r_result <= bus.ralu_r;
                r_carry  <= bus.ralu_pout;
            end
        end
    end

    assign bus.cmd_ready = r_ready;
    assign bus.DataIn    = r_datain;
    assign bus.S         = r_s;
    assign bus.M         = r_m;
    assign bus.Pin       = 1'b0;
    assign bus.ISR       = 1'b0;
    assign bus.ISL       = 1'b0;
    assign bus.A         = r_a;
    assign bus.wr        = r_wr;
    assign bus.adr       = r_adr;
    assign bus.v         = r_v;
    assign bus.done      = r_done;
    assign bus.result    = r_result;
    assign bus.carry     = r_carry;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_ralu_sequencer.sv
// Scoreboard bench for ralu_sequencer: stimulus pushes the expected step words and
// completion into queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_ralu_sequencer;
    localparam int unsigned AW = 3;
    localparam int unsigned DW = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    ralu_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    ralu_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [17:0] word;   // {DataIn,S,M,A,wr,adr,v}
        bit          fin;
    } wexp_t;
    typedef struct {
        int   cyc;
        logic err;
        bit   fin;
    } dexp_t;

    wexp_t wq[$];
    dexp_t dq[$];
    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit mon_en = 0;
    logic [DW-1:0] last_r = '0;
    logic          last_c = 1'b0;
    logic [DW-1:0] pend_r = '0;
    logic          pend_c = 1'b0;

    always @(posedge clock) cyc++;

    // RALU stand-in: random R/Pout each cycle
    always @(posedge clock) begin
        #1;
        bus.ralu_r    = DW'($urandom);
        bus.ralu_pout = 1'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [17:0] mk(input logic [DW-1:0] d, input logic [3:0] s, input logic m,
                                       input logic a, input logic w, input logic [AW-1:0] ad,
                                       input logic [3:0] vv);
        return {d, s, m, a, w, ad, vv};
    endfunction

    function automatic logic [17:0] cur_word();
        return {bus.DataIn, bus.S, bus.M, bus.A, bus.wr, bus.adr, bus.v};
    endfunction

    // Reference: expand a macro-command into its step list and completion time
    function automatic void model(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] ra,
                                  input logic [AW-1:0] rb, input logic [DW-1:0] imm, input int acc);
        int   lat;
        bit   fin;
        logic e;
        int   n;
        logic [3:0] cntv;
        lat = 1; fin = 0; e = 1'b0;
        case (op)
            3'b000: ;
            3'b001: begin
                wq.push_back('{mk(imm, 4'd0, 0, 1, 0, '0, 4'b0001), 0});
                wq.push_back('{mk('0, 4'd0, 0, 0, 1, rd, 4'b0000), 1});
                lat = 3; fin = 1;
            end
            3'b011, 3'b101: begin
                wq.push_back('{mk('0, 4'd0, 0, 0, 0, ra, 4'b0001), 0});
                wq.push_back('{mk('0, 4'd0, 0, 0, 0, rb, 4'b0110), 0});
                if (op == 3'b011) wq.push_back('{mk('0, 4'b1001, 1, 0, 1, rd, 4'b0000), 1});
                else              wq.push_back('{mk('0, 4'b0100, 0, 0, 0, '0, 4'b0000), 1});
                lat = 4; fin = 1;
            end
            3'b100: begin
                cntv = 4'(imm) & 4'd3;
                n = int'(cntv) + 1;
                wq.push_back('{mk('0, 4'd0, 0, 0, 0, ra, 4'b0110), 0});
                for (int i = 0; i < n; i++) begin
                    if (i == n - 1) wq.push_back('{mk('0, 4'b0101, 0, 0, 1, rd, 4'b0010), 1});
                    else            wq.push_back('{mk('0, 4'b0101, 0, 0, 0, '0, 4'b0010), 0});
                end
                lat = 2 + n; fin = 1;
            end
            default: e = 1'b1;
        endcase
        dq.push_back('{acc + lat - 1, e, fin});
    endfunction

    // Monitor
    always @(negedge clock) begin
        if (mon_en && reset) begin
            wexp_t we;
            dexp_t de;
            logic [17:0] w;
            chk("pin_isr_isl", 32'({bus.Pin, bus.ISR, bus.ISL}), 32'd0);
            w = cur_word();
            if (w != 18'd0) begin
                chk("err_cleared_in_step", 32'(bus.err), 32'd0);
                if (wq.size() == 0) begin
                    chk("unexpected_word", 32'(w), 32'd0);
                end else begin
                    we = wq.pop_front();
                    chk("ctrl_word", 32'(w), 32'(we.word));
                    if (we.fin) begin
                        pend_r = bus.ralu_r;
                        pend_c = bus.ralu_pout;
                    end
                end
            end
            if (bus.done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    de = dq.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(de.cyc));
                    chk("err", 32'(bus.err), 32'(de.err));
                    chk("ready_low_in_done", 32'(bus.cmd_ready), 32'd0);
                    if (de.fin) begin
                        last_r = pend_r;
                        last_c = pend_c;
                    end
                    chk("result", 32'(bus.result), 32'(last_r));
                    chk("carry", 32'(bus.carry), 32'(last_c));
                end
            end
        end
    end

    // Present a command, wait for acceptance, hand it to the model
    task automatic send(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] ra,
                        input logic [AW-1:0] rb, input logic [DW-1:0] imm, input bit hold);
        int t;
        @(negedge clock);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_ra    = ra;
        bus.cmd_rb    = rb;
        bus.cmd_imm   = imm;
        t = 0;
        while (!bus.cmd_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!bus.cmd_ready) begin
            chk("accept_timeout", 32'(bus.cmd_ready), 32'd1);
            bus.cmd_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            model(op, rd, ra, rb, imm, cyc);
            if (!hold) bus.cmd_valid = 1'b0;
        end
    endtask

    initial begin
        int t;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_rd    = '0;
        bus.cmd_ra    = '0;
        bus.cmd_rb    = '0;
        bus.cmd_imm   = '0;
        bus.ralu_r    = '0;
        bus.ralu_pout = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_carry", 32'(bus.carry), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_word", 32'(cur_word()), 32'd0);

        // Reset while ADD is in its second step
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 3'b011; bus.cmd_ra = 3'd0; bus.cmd_rb = 3'd1; bus.cmd_rd = 3'd1;
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clock);
        chk("abort_ld_a", 32'(cur_word()), 32'(mk('0, 4'd0, 0, 0, 0, 3'd0, 4'b0001)));
        @(negedge clock);
        chk("abort_ld_b", 32'(cur_word()), 32'(mk('0, 4'd0, 0, 0, 0, 3'd1, 4'b0110)));
        reset = 1'b0;
        #1;
        chk("abort_idle_word", 32'(cur_word()), 32'd0);
        chk("abort_wr", 32'(bus.wr), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        last_r = '0;
        last_c = 1'b0;
        mon_en = 1'b1;
        @(negedge clock);
        chk("post_abort_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (4) @(negedge clock);

        // Directed commands
        send(3'b001, 3'd0, 3'd0, 3'd0, 4'd4, 0);
        send(3'b011, 3'd1, 3'd0, 3'd1, 4'd0, 0);
        send(3'b100, 3'd0, 3'd0, 3'd0, 4'd2, 0);
        send(3'b100, 3'd5, 3'd3, 3'd0, 4'd3, 0);
        send(3'b100, 3'd2, 3'd6, 3'd0, 4'd0, 0);
        send(3'b101, 3'd0, 3'd2, 3'd3, 4'd0, 1);
        send(3'b001, 3'd7, 3'd0, 3'd0, 4'd9, 0);
        send(3'b111, 3'd0, 3'd0, 3'd0, 4'd0, 0);
        send(3'b001, 3'd3, 3'd0, 3'd0, 4'd15, 0);
        send(3'b000, 3'd0, 3'd0, 3'd0, 4'd0, 1);
        send(3'b010, 3'd0, 3'd0, 3'd0, 4'd0, 0);

        // Random commands, including reserved ops and held-valid back-to-back
        for (int i = 0; i < 200; i++) begin
            send(3'($urandom_range(0, 7)), AW'($urandom), AW'($urandom), AW'($urandom),
                 DW'($urandom), 1'($urandom));
            if (!bus.cmd_valid) repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        @(negedge clock);
        bus.cmd_valid = 1'b0;

        t = 0;
        while ((wq.size() != 0 || dq.size() != 0) && t < 200) begin
            @(negedge clock);
            t++;
        end
        chk("drain_words", 32'(wq.size()), 32'd0);
        chk("drain_done", 32'(dq.size()), 32'd0);
        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
